// File: rtl/matmul_read_scheduler.sv
// Read sequencer for the A-row / B-column loader BRAMs: walks every (i, j) pair of the
// selected sub-matrix row-major and hands each BRAM output pair to the dot-product unit.
module matmul_read_scheduler #(
    parameter int MAX_SIZE_A   = 32,
    parameter int MAX_SIZE_B   = 32,
    parameter int READ_LATENCY = 2,
    localparam int AW_A = $clog2(MAX_SIZE_A),
    localparam int AW_B = $clog2(MAX_SIZE_B)
) (
    input  logic            inter_refclk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW_A-1:0] num_rows_m1,
    input  logic [AW_B-1:0] num_cols_m1,
    output logic [AW_A-1:0] a_addr,
    output logic [AW_B-1:0] b_addr,
    output logic            rd_en,
    output logic            rd_regce,
    output logic            dp_valid,
    input  logic            dp_ready,
    output logic [AW_A-1:0] dp_row,
    output logic [AW_B-1:0] dp_col,
    output logic            busy,
    output logic            done
);

    localparam int LW = 2;
    localparam logic [LW-1:0] LAT_LOAD = LW'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [AW_A-1:0] i_q, i_d, rows_q, rows_d;
    logic [AW_B-1:0] j_q, j_d, cols_q, cols_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [AW_A-1:0] a_addr_q, a_addr_d, dp_row_q, dp_row_d;
    logic [AW_B-1:0] b_addr_q, b_addr_d, dp_col_q, dp_col_d;
    logic            rd_en_q, rd_en_d, rd_regce_q, rd_regce_d;
    logic            dp_valid_q, dp_valid_d, busy_q, busy_d, done_q, done_d;

    always_ff @(posedge inter_refclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            lat_q      <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            dp_row_q   <= '0;
            dp_col_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_regce_q <= 1'b0;
            dp_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            lat_q      <= lat_d;
            a_addr_q   <= a_addr_d;
            b_addr_q   <= b_addr_d;
            dp_row_q   <= dp_row_d;
            dp_col_q   <= dp_col_d;
            rd_en_q    <= rd_en_d;
            rd_regce_q <= rd_regce_d;
            dp_valid_q <= dp_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        lat_d   = lat_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d  = num_rows_m1;
                    cols_d  = num_cols_m1;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = (READ_LATENCY > 1) ? S_WAIT : S_PRESENT;
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_PRESENT;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            S_PRESENT: begin
                // Equality compares only, so a full-size pass never wraps the indices.
                if (dp_ready) begin
                    if (j_q != cols_q) begin
                        j_d     = j_q + AW_B'(1);
                        state_d = S_ISSUE;
                    end else if (i_q != rows_q) begin
                        j_d     = '0;
                        i_d     = i_q + AW_A'(1);
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every port is a clean flop output.
    always_comb begin
        a_addr_d   = a_addr_q;
        b_addr_d   = b_addr_q;
        dp_row_d   = dp_row_q;
        dp_col_d   = dp_col_q;
        rd_en_d    = (state_d == S_ISSUE);
        rd_regce_d = (state_q == S_ISSUE) && (state_d == S_WAIT);
        dp_valid_d = (state_d == S_PRESENT);
        busy_d     = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_PRESENT);
        done_d     = (state_d == S_FINISH);
        if (state_d == S_ISSUE) begin
            a_addr_d = i_d;
            b_addr_d = j_d;
            dp_row_d = i_d;
            dp_col_d = j_d;
        end
    end

    assign a_addr   = a_addr_q;
    assign b_addr   = b_addr_q;
    assign rd_en    = rd_en_q;
    assign rd_regce = rd_regce_q;
    assign dp_valid = dp_valid_q;
    assign dp_row   = dp_row_q;
    assign dp_col   = dp_col_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_matmul_read_scheduler.sv
// Bench for matmul_read_scheduler: cycle-level expectation model plus directed passes
// with hand-computed cycle offsets, pair orders and counts.
module tb_matmul_read_scheduler;

    localparam int MAX_A = 32;
    localparam int MAX_B = 32;
    localparam int RL    = 2;
    localparam int AW_A  = $clog2(MAX_A);
    localparam int AW_B  = $clog2(MAX_B);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            dp_ready = 1'b0;
    logic [AW_A-1:0] num_rows_m1 = '0;
    logic [AW_B-1:0] num_cols_m1 = '0;
    logic [AW_A-1:0] a_addr, dp_row;
    logic [AW_B-1:0] b_addr, dp_col;
    logic            rd_en, rd_regce, dp_valid, busy, done;

    always #5 clk = ~clk;

    matmul_read_scheduler #(
        .MAX_SIZE_A  (MAX_A),
        .MAX_SIZE_B  (MAX_B),
        .READ_LATENCY(RL)
    ) dut (
        .inter_refclk(clk),
        .rst         (rst),
        .start       (start),
        .num_rows_m1 (num_rows_m1),
        .num_cols_m1 (num_cols_m1),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .rd_en       (rd_en),
        .rd_regce    (rd_regce),
        .dp_valid    (dp_valid),
        .dp_ready    (dp_ready),
        .dp_row      (dp_row),
        .dp_col      (dp_col),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected outputs for the current cycle, derived from events of earlier cycles.
    bit e_rd_en = 0, e_regce = 0, e_valid = 0, e_busy = 0, e_done = 0, e_zero = 1, rd_prev = 0;
    int m_r = 1, m_c = 1, m_k = 0;

    int acc_log[$], done_log[$], hs_cyc_log[$], hs_row_log[$], hs_col_log[$], rd_log[$];

    bit end_req = 0;
    bit tmo[7];
    int idle_done, idle_hs;
    int a2, d2, h2, r2, h2e;
    int h3, h3e;
    int st_valid[5], st_row[5], st_col[5], st_rd[5];
    int a4, d4, h4, a4e, d4e, h4e;
    int d5, h5, d5e, h5e;
    int d6, d6b, h6, h6e, d6e;
    int r6_valid, r6_busy, r6_done, r6_rd, r6_row, r6_col, r6_aaddr;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int idx);
        return (idx >= 0 && idx < q.size()) ? q[idx] : -1;
    endfunction

    always @(negedge clk) begin
        bit hs, fin, acc, n_valid;
        int s;
        if (end_req) begin
            check("idle_done", idle_done, 0);
            check("idle_pairs", idle_hs, 0);
            s = qat(acc_log, a2);
            check("t2_done_offset", qat(done_log, d2) - s, 19);
            check("t2_last_hs_offset", qat(hs_cyc_log, h2 + 5) - s, 18);
            check("t2_rd0_offset", qat(rd_log, r2) - s, 1);
            check("t2_rd1_offset", qat(rd_log, r2 + 1) - s, 4);
            check("t2_rd2_offset", qat(rd_log, r2 + 2) - s, 7);
            check("t2_rd5_offset", qat(rd_log, r2 + 5) - s, 16);
            check("t2_pairs", h2e - h2, 6);
            for (int k = 0; k < 6; k++) begin
                check("t2_row", qat(hs_row_log, h2 + k), k / 3);
                check("t2_col", qat(hs_col_log, h2 + k), k % 3);
            end
            for (int k = 0; k < 5; k++) begin
                check("t3_hold_valid", st_valid[k], 1);
                check("t3_hold_row", st_row[k], 0);
                check("t3_hold_col", st_col[k], 1);
                check("t3_hold_rd", st_rd[k], 0);
            end
            check("t3_pairs", h3e - h3, 3);
            check("t3_stall_gap", qat(hs_cyc_log, h3 + 1) - qat(hs_cyc_log, h3), 8);
            check("t4_pairs", h4e - h4, 1);
            check("t4_accepts", a4e - a4, 1);
            check("t4_dones", d4e - d4, 1);
            check("t4_row", qat(hs_row_log, h4), 0);
            check("t4_col", qat(hs_col_log, h4), 0);
            check("t5_pairs", h5e - h5, 1024);
            check("t5_dones", d5e - d5, 1);
            check("t5_last_row", qat(hs_row_log, h5e - 1), 31);
            check("t5_last_col", qat(hs_col_log, h5e - 1), 31);
            check("t6_rst_valid", r6_valid, 0);
            check("t6_rst_busy", r6_busy, 0);
            check("t6_rst_done", r6_done, 0);
            check("t6_rst_rd", r6_rd, 0);
            check("t6_rst_row", r6_row, 0);
            check("t6_rst_col", r6_col, 0);
            check("t6_rst_aaddr", r6_aaddr, 0);
            check("t6_no_done_after_rst", d6b - d6, 0);
            check("t6_restart_pairs", h6e - h6, 1);
            check("t6_restart_dones", d6e - d6b, 1);
            check("t6_restart_row", qat(hs_row_log, h6), 0);
            check("t6_restart_col", qat(hs_col_log, h6), 0);
            for (int k = 0; k < 7; k++) check("timeout", int'(tmo[k]), 0);
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $finish;
        end else begin
            cyc++;
            check("rd_en", int'(rd_en), int'(e_rd_en));
            check("rd_regce", int'(rd_regce), int'(e_regce));
            check("dp_valid", int'(dp_valid), int'(e_valid));
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
            if (e_valid || e_rd_en || e_done) begin
                check("dp_row", int'(dp_row), m_k / m_c);
                check("dp_col", int'(dp_col), m_k % m_c);
            end
            if (e_rd_en) begin
                check("a_addr", int'(a_addr), m_k / m_c);
                check("b_addr", int'(b_addr), m_k % m_c);
            end
            if (e_zero) begin
                check("a_addr_zero", int'(a_addr), 0);
                check("b_addr_zero", int'(b_addr), 0);
                check("dp_row_zero", int'(dp_row), 0);
                check("dp_col_zero", int'(dp_col), 0);
            end

            if (dp_valid && dp_ready && !rst) begin
                hs_cyc_log.push_back(cyc);
                hs_row_log.push_back(int'(dp_row));
                hs_col_log.push_back(int'(dp_col));
                $display("pair cycle %0d row %0d col %0d", cyc, dp_row, dp_col);
            end
            if (rd_en) rd_log.push_back(cyc);
            if (done) done_log.push_back(cyc);

            hs  = e_valid && dp_ready && !rst;
            fin = hs && (m_k == m_r * m_c - 1);
            acc = start && !e_busy && !e_done && !rst;
            if (acc) acc_log.push_back(cyc);

            if (rst) begin
                e_rd_en = 0; e_regce = 0; e_valid = 0; e_busy = 0; e_done = 0;
                e_zero = 1; rd_prev = 0;
            end else begin
                n_valid = ((RL == 1) ? e_rd_en : rd_prev) || (e_valid && !hs);
                rd_prev = e_rd_en;
                e_regce = (RL == 2) && e_rd_en;
                e_rd_en = acc || (hs && !fin);
                e_valid = n_valid;
                e_done  = fin;
                e_busy  = (e_busy && !fin) || acc;
                if (acc) begin
                    m_r = int'(num_rows_m1) + 1;
                    m_c = int'(num_cols_m1) + 1;
                    m_k = 0;
                    e_zero = 0;
                end
                if (hs && !fin) m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, input int slot);
        int n = 0;
        while (done_log.size() == base && n < limit) begin
            tick();
            n++;
        end
        tmo[slot] = (done_log.size() == base);
    endtask

    task automatic wait_pair(input int row, input int col, input int limit, input int slot);
        int n = 0;
        while (!(dp_valid && int'(dp_row) == row && int'(dp_col) == col) && n < limit) begin
            tick();
            n++;
        end
        tmo[slot] = !(dp_valid && int'(dp_row) == row && int'(dp_col) == col);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        idle_done = done_log.size();
        idle_hs   = hs_cyc_log.size();

        // 2x3 pass with dp_ready held high
        num_rows_m1 = 5'd1; num_cols_m1 = 5'd2; dp_ready = 1'b1;
        a2 = acc_log.size(); d2 = done_log.size(); h2 = hs_cyc_log.size(); r2 = rd_log.size();
        pulse_start();
        wait_done(d2, 100, 0);
        tick();
        h2e = hs_cyc_log.size();

        // 1x3 pass with a five-cycle stall on pair (0,1)
        num_rows_m1 = 5'd0; num_cols_m1 = 5'd2; dp_ready = 1'b0;
        h3 = hs_cyc_log.size();
        pulse_start();
        wait_pair(0, 0, 50, 1);
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        wait_pair(0, 1, 50, 2);
        for (int k = 0; k < 5; k++) begin
            st_valid[k] = int'(dp_valid);
            st_row[k]   = int'(dp_row);
            st_col[k]   = int'(dp_col);
            st_rd[k]    = int'(rd_en | rd_regce);
            tick();
        end
        dp_ready = 1'b1;
        wait_done(done_log.size(), 100, 3);
        tick();
        h3e = hs_cyc_log.size();

        // 1x1 pass with a second start while busy
        num_rows_m1 = 5'd0; num_cols_m1 = 5'd0;
        a4 = acc_log.size(); d4 = done_log.size(); h4 = hs_cyc_log.size();
        pulse_start();
        tick();
        pulse_start();
        wait_done(d4, 100, 4);
        repeat (5) tick();
        a4e = acc_log.size(); d4e = done_log.size(); h4e = hs_cyc_log.size();

        // full 32x32 pass with random back-pressure
        num_rows_m1 = 5'd31; num_cols_m1 = 5'd31;
        d5 = done_log.size(); h5 = hs_cyc_log.size();
        pulse_start();
        begin
            int n = 0;
            while (done_log.size() == d5 && n < 20000) begin
                dp_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            tmo[5] = (done_log.size() == d5);
        end
        dp_ready = 1'b1;
        repeat (3) tick();
        d5e = done_log.size(); h5e = hs_cyc_log.size();

        // reset during pair (2,5) of a 4x8 pass, then a 1x1 restart
        num_rows_m1 = 5'd3; num_cols_m1 = 5'd7;
        d6 = done_log.size();
        pulse_start();
        wait_pair(2, 5, 500, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r6_valid = int'(dp_valid); r6_busy = int'(busy); r6_done = int'(done);
        r6_rd = int'(rd_en | rd_regce); r6_row = int'(dp_row); r6_col = int'(dp_col);
        r6_aaddr = int'(a_addr);
        repeat (5) tick();
        d6b = done_log.size();
        num_rows_m1 = 5'd0; num_cols_m1 = 5'd0;
        h6 = hs_cyc_log.size();
        pulse_start();
        wait_done(d6b, 100, 6);
        tick();
        h6e = hs_cyc_log.size(); d6e = done_log.size();

        tick();
        end_req = 1'b1;
    end

endmodule
